// File: rtl/cpu_pkg.sv
// cpu_pkg: shared condition codes, NZCV bit positions and flag-write type
package cpu_pkg;
  typedef enum logic [3:0] {EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV} cond_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef logic [1:0] flagw_t;
endpackage

// File: rtl/cond_flag_unit_if.sv
// cond_flag_unit_if: decoder-side request and gated-strobe bundle of the flag unit
interface cond_flag_unit_if #(parameter int CNT_W = 32);
  import cpu_pkg::*;
  logic instr_valid;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  flagw_t flag_w;
  logic pcs;
  logic reg_w;
  logic mem_w;
  logic no_write;
  logic pc_src;
  logic reg_write;
  logic mem_write;
  logic cond_ex;
  logic [3:0] flags_q;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] squash_cnt;
  modport master (output instr_valid, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write,
                  input pc_src, reg_write, mem_write, cond_ex, flags_q, exec_cnt, squash_cnt);
  modport slave (input instr_valid, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write,
                 output pc_src, reg_write, mem_write, cond_ex, flags_q, exec_cnt, squash_cnt);
endinterface

// File: rtl/cond_check.sv
// cond_check: evaluates an ARM condition field against NZCV flags
module cond_check
  import cpu_pkg::*;
(
  input  cond_e      cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = {flags[FLAG_N], flags[FLAG_Z], flags[FLAG_C], flags[FLAG_V]};
  always_comb begin
    pass = 1'b1;
    case (cond)
      EQ: pass = z;
      NE: pass = !z;
      CS: pass = c;
      CC: pass = !c;
      MI: pass = n;
      PL: pass = !n;
      VS: pass = v;
      VC: pass = !v;
      HI: pass = c & !z;
      LS: pass = !c | z;
      GE: pass = n == v;
      LT: pass = n != v;
      GT: pass = !z & (n == v);
      LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end
endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV register, condition gating of write strobes, exec/squash counters
module cond_flag_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter bit REG_OUT = 0
) (
  input logic clk,
  input logic rst_n,
  cond_flag_unit_if.slave bus
);
  logic [3:0] flags;
  logic [CNT_W-1:0] exec_cnt, squash_cnt;
  logic pass, ex, pc_c, rw_c, mw_c;
  cond_check u_chk (.cond(cond_e'(bus.cond)), .flags(flags), .pass(pass));
  assign ex   = bus.instr_valid & pass;
  assign pc_c = bus.pcs & ex;
  assign rw_c = bus.reg_w & ex & !bus.no_write;
  assign mw_c = bus.mem_w & ex;
  // Flags update only on a passing instruction; readers see the new value next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags      <= '0;
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else begin
      if (ex && bus.flag_w[1]) flags[FLAG_N:FLAG_Z] <= bus.alu_flags[FLAG_N:FLAG_Z];
      if (ex && bus.flag_w[0]) flags[FLAG_C:FLAG_V] <= bus.alu_flags[FLAG_C:FLAG_V];
      if (ex && !(&exec_cnt)) exec_cnt <= exec_cnt + 1'b1;
      if (bus.instr_valid && !ex && !(&squash_cnt)) squash_cnt <= squash_cnt + 1'b1;
    end
  end
  generate
    if (REG_OUT) begin : g_reg
      logic [3:0] strb;
      always_ff @(posedge clk) strb <= !rst_n ? 4'b0 : {pc_c, rw_c, mw_c, ex};
      assign {bus.pc_src, bus.reg_write, bus.mem_write, bus.cond_ex} = strb;
    end else begin : g_comb
      assign {bus.pc_src, bus.reg_write, bus.mem_write, bus.cond_ex} = {pc_c, rw_c, mw_c, ex};
    end
  endgenerate
  assign bus.flags_q    = flags;
  assign bus.exec_cnt   = exec_cnt;
  assign bus.squash_cnt = squash_cnt;
endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: directed checks of a combinational (32-bit) and a registered (4-bit counter) instance
module tb_cond_flag_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iv = 1'b0, p = 1'b0, r = 1'b0, m = 1'b0, nw = 1'b0;
  logic [3:0] cnd = 4'h0, af = 4'h0;
  logic [1:0] fw = 2'b00;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cond_flag_unit_if #(.CNT_W(32)) b0 ();
  cond_flag_unit_if #(.CNT_W(4))  b1 ();
  assign {b0.instr_valid, b0.cond, b0.alu_flags, b0.flag_w, b0.pcs, b0.reg_w, b0.mem_w, b0.no_write} = {iv, cnd, af, fw, p, r, m, nw};
  assign {b1.instr_valid, b1.cond, b1.alu_flags, b1.flag_w, b1.pcs, b1.reg_w, b1.mem_w, b1.no_write} = {iv, cnd, af, fw, p, r, m, nw};
  cond_flag_unit #(.CNT_W(32), .REG_OUT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  cond_flag_unit #(.CNT_W(4),  .REG_OUT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return (c[3:1] == 3'd7) ? 1'b1 : (b ^ c[0]);
  endfunction

  task automatic issue(input logic [3:0] c, input logic [3:0] a, input logic [1:0] w,
                       input logic pp, input logic rr, input logic mm, input logic nn);
    iv = 1'b1; cnd = c; af = a; fw = w; p = pp; r = rr; m = mm; nw = nn;
  endtask

  task automatic idle();
    iv = 1'b0; p = 1'b0; r = 1'b0; m = 1'b0; nw = 1'b0; fw = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] f);
    issue(4'hE, f, 2'b11, 0, 0, 0, 0);
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    iv = 1'b0; cnd = 4'hE; af = 4'hF; fw = 2'b11; p = 1'b1; r = 1'b1; m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({b0.pc_src, b0.reg_write, b0.mem_write, b0.cond_ex} !== 4'b0) begin
        errors++; $display("FAIL reset_strobes0 got %b want 0000", {b0.pc_src, b0.reg_write, b0.mem_write, b0.cond_ex});
      end
      tick();
    end
    checks++;
    if (b0.flags_q !== 4'b0000 || b1.flags_q !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b/%b want 0000", b0.flags_q, b1.flags_q);
    end
    checks++;
    if (b0.exec_cnt !== 0 || b0.squash_cnt !== 0 || b1.exec_cnt !== 0 || b1.squash_cnt !== 0) begin
      errors++; $display("FAIL reset_counts got %0d %0d %0d %0d want 0", b0.exec_cnt, b0.squash_cnt, b1.exec_cnt, b1.squash_cnt);
    end
    checks++;
    if ({b1.pc_src, b1.reg_write, b1.mem_write, b1.cond_ex} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes1 got %b want 0000", {b1.pc_src, b1.reg_write, b1.mem_write, b1.cond_ex});
    end
    idle();
  endtask

  task automatic test_eq_ne();
    issue(4'hE, 4'b0100, 2'b11, 0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (b0.reg_write !== 1'b1 || b0.cond_ex !== 1'b1) begin
      errors++; $display("FAIL al_regw got rw=%b ex=%b want 1 1", b0.reg_write, b0.cond_ex);
    end
    tick();
    checks++;
    if (b0.flags_q !== 4'b0100 || b1.reg_write !== 1'b1) begin
      errors++; $display("FAIL al_flags got %b rw1=%b want 0100 1", b0.flags_q, b1.reg_write);
    end
    issue(4'h0, 4'b0000, 2'b00, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (b0.pc_src !== 1'b1) begin
      errors++; $display("FAIL eq_pcsrc got %b want 1", b0.pc_src);
    end
    tick();
    checks++;
    if (b1.pc_src !== 1'b1 || b0.exec_cnt !== 2) begin
      errors++; $display("FAIL eq_reg got pc1=%b exec=%0d want 1 2", b1.pc_src, b0.exec_cnt);
    end
    issue(4'h1, 4'b0000, 2'b00, 0, 0, 1, 0);
    @(negedge clk);
    checks++;
    if (b0.mem_write !== 1'b0 || b0.cond_ex !== 1'b0) begin
      errors++; $display("FAIL ne_memw got mw=%b ex=%b want 0 0", b0.mem_write, b0.cond_ex);
    end
    tick();
    idle();
    checks++;
    if (b0.squash_cnt !== 1 || b0.exec_cnt !== 2 || b1.mem_write !== 1'b0 || b1.cond_ex !== 1'b0) begin
      errors++; $display("FAIL ne_counts got sq=%0d ex=%0d mw1=%b ex1=%b want 1 2 0 0", b0.squash_cnt, b0.exec_cnt, b1.mem_write, b1.cond_ex);
    end
    tick();
    checks++;
    if (b0.squash_cnt !== 1 || b0.exec_cnt !== 2 || b0.flags_q !== 4'b0100) begin
      errors++; $display("FAIL idle_hold got sq=%0d ex=%0d f=%b want 1 2 0100", b0.squash_cnt, b0.exec_cnt, b0.flags_q);
    end
  endtask

  task automatic test_partial();
    load_flags(4'b1111);
    issue(4'hE, 4'b0000, 2'b10, 0, 0, 0, 0);
    tick();
    checks++;
    if (b0.flags_q !== 4'b0011) begin
      errors++; $display("FAIL partial_nz got %b want 0011", b0.flags_q);
    end
    issue(4'hE, 4'b0000, 2'b01, 0, 0, 0, 0);
    tick();
    checks++;
    if (b0.flags_q !== 4'b0000) begin
      errors++; $display("FAIL partial_cv got %b want 0000", b0.flags_q);
    end
    load_flags(4'b0011);
    issue(4'h8, 4'b0000, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (b0.cond_ex !== 1'b1) begin
      errors++; $display("FAIL hi_pass got %b want 1", b0.cond_ex);
    end
    tick();
    idle();
  endtask

  task automatic test_fail_nowrite();
    load_flags(4'b0000);
    issue(4'h0, 4'b0100, 2'b11, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (b0.cond_ex !== 1'b0) begin
      errors++; $display("FAIL eq_fail_ex got %b want 0", b0.cond_ex);
    end
    tick();
    idle();
    checks++;
    if (b0.flags_q !== 4'b0000) begin
      errors++; $display("FAIL eq_fail_flags got %b want 0000", b0.flags_q);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] fs [4] = '{4'b1000, 4'b1001, 4'b0100, 4'b0001};
    for (int k = 0; k < 4; k++) begin
      load_flags(fs[k]);
      for (int c = 0; c < 16; c++) begin
        issue(c[3:0], 4'b1111, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (b0.cond_ex !== ref_pass(c[3:0], fs[k])) begin
          errors++; $display("FAIL sweep f=%b c=%h got %b want %b", fs[k], c, b0.cond_ex, ref_pass(c[3:0], fs[k]));
        end
        tick();
      end
    end
    idle();
    load_flags(4'b1001);
    issue(4'hA, 4'b0000, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (b0.cond_ex !== 1'b1) begin
      errors++; $display("FAIL ge_1001 got %b want 1", b0.cond_ex);
    end
    tick();
    load_flags(4'b1000);
    issue(4'hB, 4'b0000, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (b0.cond_ex !== 1'b1) begin
      errors++; $display("FAIL lt_1000 got %b want 1", b0.cond_ex);
    end
    tick();
    idle();
  endtask

  task automatic test_no_write();
    issue(4'hE, 4'b1010, 2'b11, 0, 1, 0, 1);
    @(negedge clk);
    checks++;
    if (b0.reg_write !== 1'b0 || b0.cond_ex !== 1'b1) begin
      errors++; $display("FAIL nowrite_rw got rw=%b ex=%b want 0 1", b0.reg_write, b0.cond_ex);
    end
    tick();
    idle();
    checks++;
    if (b0.flags_q !== 4'b1010 || b1.reg_write !== 1'b0) begin
      errors++; $display("FAIL nowrite_flags got %b rw1=%b want 1010 0", b0.flags_q, b1.reg_write);
    end
  endtask

  task automatic test_reset_collide();
    issue(4'hE, 4'b0110, 2'b11, 1, 1, 1, 0);
    rst_n = 1'b0;
    tick();
    checks++;
    if (b0.flags_q !== 4'b0000 || b1.flags_q !== 4'b0000) begin
      errors++; $display("FAIL rst_collide_flags got %b/%b want 0000", b0.flags_q, b1.flags_q);
    end
    checks++;
    if ({b1.pc_src, b1.reg_write, b1.mem_write, b1.cond_ex} !== 4'b0 || b0.exec_cnt !== 0) begin
      errors++; $display("FAIL rst_collide_out got %b exec=%0d want 0000 0", {b1.pc_src, b1.reg_write, b1.mem_write, b1.cond_ex}, b0.exec_cnt);
    end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_saturation();
    issue(4'hE, 4'b0000, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    idle();
    checks++;
    if (b1.exec_cnt !== 4'd15 || b1.squash_cnt !== 4'd0) begin
      errors++; $display("FAIL sat_exec got %0d sq=%0d want 15 0", b1.exec_cnt, b1.squash_cnt);
    end
    checks++;
    if (b0.exec_cnt !== 20) begin
      errors++; $display("FAIL wide_exec got %0d want 20", b0.exec_cnt);
    end
    load_flags(4'b0000);
    issue(4'h0, 4'b0000, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) tick();
    idle();
    tick();
    checks++;
    if (b1.squash_cnt !== 4'd15 || b1.exec_cnt !== 4'd15 || b0.squash_cnt !== 18) begin
      errors++; $display("FAIL sat_squash got %0d ex=%0d wide=%0d want 15 15 18", b1.squash_cnt, b1.exec_cnt, b0.squash_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_eq_ne();
    test_partial();
    test_fail_nowrite();
    test_sweep();
    test_no_write();
    test_reset_collide();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
Consumer end of the ALU's 4-bit Flags output. It holds the architectural NZCV register, written from ALU flags under per-group write enables. It evaluates the 4-bit ARM condition field of each incoming instruction against the stored flags and gates PC, register and memory write strobes. It sits between the decoder and the datapath in the single-cycle/pipelined CPU, and also counts executed versus squashed instructions.

Parameters:
CNT_W, 32, width of the executed/squashed counters (saturating)
REG_OUT, 0, 0 = gated strobes are combinational from the current inputs; 1 = strobes are registered, adding one cycle of latency

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  the cond, write-request and FlagW inputs are meaningful this cycle
cond  in  4  instruction condition field [31:28]
alu_flags  in  4  ALU Flags, ordered {N,Z,C,V} as bits [3:0]
flag_w  in  2  bit1 = write the N,Z group; bit0 = write the C,V group
pcs  in  1  instruction requests a PC write
reg_w  in  1  instruction requests a register write
mem_w  in  1  instruction requests a memory write
no_write  in  1  compare-type instruction; suppresses reg_w
pc_src  out  1  gated PC write
reg_write  out  1  gated register write
mem_write  out  1  gated memory write
cond_ex  out  1  the condition passed for the current instruction
flags_q  out  4  stored NZCV
exec_cnt  out  CNT_W  count of executed valid instructions
squash_cnt  out  CNT_W  count of squashed valid instructions

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - flags_q = 4'b0000; exec_cnt = 0; squash_cnt = 0.
  - Registered strobes (REG_OUT = 1) = 0.
  - Reset has priority over every update in the same cycle.
- Condition decode, combinational from flags_q (the pre-update value), using {N,Z,C,V} = flags_q:
  - 0 EQ: Z; 1 NE: !Z
  - 2 CS: C; 3 CC: !C
  - 4 MI: N; 5 PL: !N
  - 6 VS: V; 7 VC: !V
  - 8 HI: C & !Z; 9 LS: !C | Z
  - A GE: N == V; B LT: N != V
  - C GT: !Z & (N == V); D LE: Z | (N != V)
  - E AL: 1; F: 1 (treated as AL)
- cond_ex = instr_valid & decode(cond).
- Gated strobes:
  - pc_src = pcs & cond_ex
  - reg_write = reg_w & cond_ex & !no_write
  - mem_write = mem_w & cond_ex
- Flag update on clk edge, only when cond_ex = 1:
  - flag_w[1] loads flags_q[3:2] from alu_flags[3:2].
  - flag_w[0] loads flags_q[1:0] from alu_flags[1:0].
  - The groups are independent. A failed condition leaves the flags untouched.
- Timing of the flag update: the new flags are visible to the next instruction, one cycle later. There is no same-cycle bypass; an instruction never sees its own flag result.
- REG_OUT = 1: pc_src, reg_write, mem_write and cond_ex are registered, giving one-cycle latency. flags_q timing is unchanged.
- Counters, on each clk edge with instr_valid = 1:
  - exec_cnt increments if cond_ex is 1; squash_cnt increments otherwise.
  - Both saturate at all-ones; there is no wrap-around.
  - instr_valid = 0 changes neither counter.
- instr_valid = 0: all strobes are 0, with no flag write and no counting. The flag_w, pcs, reg_w and mem_w inputs are ignored.
- Simultaneous rst_n = 0 and a valid flag-setting instruction: reset wins, and flags_q = 0 next cycle.

Decomposition:
- Shared package cpu_pkg:
  - cond_e enum with the 16 codes EQ..AL, NV.
  - Flag bit index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - flagw_t 2-bit typedef.
- Sub-module cond_check: purely combinational (cond, flags) -> pass.
  - It is reused later by the branch predictor checker.
- The top level holds the flag register, gating logic, optional output register and counters.

Test Plan:
1. Reset, then hold instr_valid = 0 for 3 cycles -> flags_q = 0000, all strobes 0, both counters 0.
2. Load and test EQ/NE:
   - First cycle: cond = E, flag_w = 11, alu_flags = 0100, reg_w = 1 -> reg_write = 1 and flags_q = 0100 next cycle.
   - Next cycle: cond = 0 (EQ), pcs = 1 -> pc_src = 1.
   - Following cycle: cond = 1 (NE), mem_w = 1 -> mem_write = 0, and squash_cnt increments by 1.
3. Partial write:
   - Set flags_q = 1111.
   - Issue AL with flag_w = 10 and alu_flags = 0000 -> flags_q = 0011.
   - Then issue HI (needs C & !Z) -> pass, with C = 1 and Z = 0.
4. Failed condition does not write flags: flags_q = 0000; issue EQ with flag_w = 11 and alu_flags = 0100 -> cond_ex = 0 and flags_q stays 0000.
5. Signed conditions: sweep all 16 conds against flags 1000, 1001, 0100 and 0001, comparing against a reference model. Example: GE with flags 1001 passes; LT with flags 1000 passes.
6. Edge cases:
   - CNT_W = 4, issue 20 valid AL instructions -> exec_cnt saturates at 15.
   - With no_write = 1, reg_w = 1, AL -> reg_write = 0, while a flag write still occurs.
   - rst_n = 0 asserted in the same cycle as a flag write -> flags_q = 0000.
